mem_ctrl: RTL and testbench

Multicycle memory interface between the control FSM and the single shared instruction/data bus. Accepts one-cycle MemoryRead/MemoryWrite commands, selects the address by IorD, and runs a req/ack bus transaction. On reads it writes an instruction into IR or an extended load value into MDR. It stretches the control FSM with mem_busy and signals completion with a one-cycle mem_done.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_load_ext.sv | 26 ++
 rtl/mem_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state type, access-size codes and lane helpers for mem_ctrl
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUS, RESP} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP = 32'h00000013;

  // sz is func3[1:0]: 00 byte, 01 half, otherwise word
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - selects the addressed byte/half of a read word and extends it
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  func3,
  output logic [31:0] load_val
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_B:    load_val = {{24{b[7]}}, b};
      F3_BU:   load_val = {24'b0, b};
      F3_H:    load_val = {{16{h[15]}}, h};
      F3_HU:   load_val = {16'b0, h};
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - multicycle req/ack memory interface feeding IR and MDR
// Define MEM_TIMEOUT_EN to abort bus waits after TIMEOUT cycles with mem_err.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic        IorD,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  mem_state_t  state;
  logic [1:0]  a_lo;
  logic [2:0]  f3_q;
  logic        to_ir;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_f3;
  logic        cmd_bad;
  logic [31:0] load_val;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
  logic [15:0] wait_cnt;
`endif

  // Fetches are always word accesses, whatever func3 holds.
  always_comb begin
    cmd_addr = IorD ? alu_out : pc;
    cmd_f3   = IorD ? func3 : F3_W;
    cmd_bad  = (cmd_f3 == 3'b011) || (cmd_f3[2:1] == 2'b11)
            || (MemoryWrite && (cmd_f3 == F3_BU || cmd_f3 == F3_HU))
            || (cmd_f3[1:0] == 2'b01 && cmd_addr[0])
            || (cmd_f3[1:0] == 2'b10 && cmd_addr[1:0] != 2'b00);
  end

  mem_load_ext u_load_ext (
    .rdata   (bus_rdata),
    .a       (a_lo),
    .func3   (f3_q),
    .load_val(load_val)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      ir        <= NOP;
      mdr       <= '0;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      a_lo      <= '0;
      f3_q      <= F3_W;
      to_ir     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: if (MemoryRead || MemoryWrite) begin
          mem_busy <= 1'b1;
          if (cmd_bad) begin
            state    <= RESP;
            mem_done <= 1'b1;
            mem_err  <= 1'b1;
          end else begin
            state     <= BUS;
            bus_req   <= 1'b1;
            bus_we    <= MemoryWrite;
            bus_addr  <= {cmd_addr[31:2], 2'b00};
            bus_be    <= lane_be(cmd_f3[1:0], cmd_addr[1:0]);
            bus_wdata <= lane_wdata(cmd_f3[1:0], wdata);
            a_lo      <= cmd_addr[1:0];
            f3_q      <= cmd_f3;
            to_ir     <= !IorD;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        BUS: if (bus_ack) begin
          bus_req  <= 1'b0;
          bus_we   <= 1'b0;
          state    <= RESP;
          mem_done <= 1'b1;
          if (!bus_we) begin
            if (to_ir) ir <= bus_rdata;
            else       mdr <= load_val;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt + 16'd1 == TO_LIMIT) begin
          bus_req  <= 1'b0;
          bus_we   <= 1'b0;
          state    <= RESP;
          mem_done <= 1'b1;
          mem_err  <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
`endif
        RESP: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a behavioural model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        MemoryRead = 1'b0, MemoryWrite = 1'b0, IorD = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, wdata = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] ir, mdr, bus_addr, bus_wdata;
  logic        mem_busy, mem_done, mem_err, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_ir  = 32'h00000013;
  logic [31:0] m_mdr = 32'h0;

  int          o_lat;
  bit          o_err, o_req, o_stable, o_done2, o_busy2, o_we;
  logic [31:0] o_addr, o_wdata, o_ir, o_mdr;
  logic [3:0]  o_be;

  mem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .IorD(IorD),
    .pc(pc), .alu_out(alu_out), .wdata(wdata), .func3(func3), .ir(ir), .mdr(mdr),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic int m_size(bit iord, logic [2:0] f3);
    if (!iord) return 4;
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic bit m_bad(bit wr, bit iord, logic [2:0] f3, logic [31:0] a);
    if (iord && (f3 == 3 || f3 >= 6 || (wr && f3 >= 4))) return 1'b1;
    return (a % m_size(iord, f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(int sz, logic [31:0] a);
    int v;
    v = ((1 << sz) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(int sz, logic [31:0] d);
    if (sz == 1) return (d % 256) * 32'h01010101;
    if (sz == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int     sz;
    longint v;
    sz = m_size(1'b1, f3);
    if (sz == 4) return rd;
    v = longint'(rd >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
    if (f3 < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // Issues one command and plays the slave; waits<0 means never acknowledge.
  task automatic run_txn(input bit wr, input bit iord, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input int waits, input logic [31:0] rd, input bit inject);
    o_lat = -1; o_err = 0; o_req = 0; o_stable = 1;
    @(negedge clk);
    MemoryRead = !wr; MemoryWrite = wr; IorD = iord; wdata = wd; func3 = f3;
    if (iord) begin alu_out = addr; pc = $urandom; end
    else begin pc = addr; alu_out = $urandom; end
    @(posedge clk); #1;
    MemoryRead = 0; MemoryWrite = 0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus_ack = 0;
      bus_rdata = $urandom;
      if (k == 0) begin
        pc = $urandom; alu_out = $urandom; wdata = $urandom; func3 = 3'($urandom);
        if (inject) begin MemoryRead = 1; IorD = 1; end
      end
      if (k == 1) MemoryRead = 0;
      if (mem_done) begin
        o_lat = k + 1; o_err = mem_err; o_ir = ir; o_mdr = mdr;
        break;
      end
      if (bus_req) begin
        if (!o_req) begin
          o_req = 1; o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
        end else if (bus_addr !== o_addr || bus_be !== o_be || bus_we !== o_we || bus_wdata !== o_wdata) begin
          o_stable = 0;
        end
        if (k == waits) begin bus_ack = 1; bus_rdata = rd; end
      end
    end
    MemoryRead = 0;
    @(posedge clk); #1;
    bus_ack = 0;
    o_done2 = mem_done; o_busy2 = mem_busy | bus_req;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (ir !== 32'h00000013) begin n_fail++; $display("FAIL reset_ir: got %h expected 00000013", ir); end
    n_tests++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL reset_mdr: got %h expected 0", mdr); end
    n_tests++; if ({mem_busy, mem_done, mem_err, bus_req, bus_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {mem_busy, mem_done, mem_err, bus_req, bus_we}); end
    n_tests++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h/%h expected 0", bus_addr, bus_be, bus_wdata); end
    @(negedge clk); clr = 0;
  endtask

  task automatic test_fetch;
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 3'b000, 2, 32'h00500093, 1'b0);
    n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr: got %h expected 00000100", o_addr); end
    n_tests++; if (o_be !== 4'b1111) begin n_fail++; $display("FAIL fetch_be: got %b expected 1111", o_be); end
    n_tests++; if (o_lat !== 4) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 4", o_lat); end
    n_tests++; if (o_ir !== 32'h00500093) begin n_fail++; $display("FAIL fetch_ir: got %h expected 00500093", o_ir); end
    n_tests++; if (o_mdr !== m_mdr) begin n_fail++; $display("FAIL fetch_mdr: got %h expected %h", o_mdr, m_mdr); end
    n_tests++; if (o_done2 !== 1'b0 || o_busy2 !== 1'b0) begin
      n_fail++; $display("FAIL fetch_done_width: got done=%b busy=%b expected 0 0", o_done2, o_busy2); end
    m_ir = 32'h00500093;
  endtask

  task automatic test_loads;
    run_txn(1'b0, 1'b1, 32'h203, 32'h0, 3'b000, 0, 32'h80AABBCC, 1'b0);
    n_tests++; if (o_mdr !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_mdr: got %h expected ffffff80", o_mdr); end
    n_tests++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b expected 1000", o_be); end
    n_tests++; if (o_lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d expected 2", o_lat); end
    n_tests++; if (o_addr !== 32'h200) begin n_fail++; $display("FAIL lb_addr: got %h expected 00000200", o_addr); end
    run_txn(1'b0, 1'b1, 32'h203, 32'h0, 3'b100, 1, 32'h80AABBCC, 1'b0);
    n_tests++; if (o_mdr !== 32'h00000080) begin n_fail++; $display("FAIL lbu_mdr: got %h expected 00000080", o_mdr); end
    run_txn(1'b0, 1'b1, 32'h202, 32'h0, 3'b001, 1, 32'h80AABBCC, 1'b0);
    n_tests++; if (o_mdr !== 32'hFFFF80AA) begin n_fail++; $display("FAIL lh_mdr: got %h expected ffff80aa", o_mdr); end
    run_txn(1'b0, 1'b1, 32'h202, 32'h0, 3'b101, 0, 32'h80AABBCC, 1'b0);
    n_tests++; if (o_mdr !== 32'h000080AA) begin n_fail++; $display("FAIL lhu_mdr: got %h expected 000080aa", o_mdr); end
    n_tests++; if (o_ir !== m_ir) begin n_fail++; $display("FAIL load_ir_kept: got %h expected %h", o_ir, m_ir); end
    m_mdr = 32'h000080AA;
  endtask

  task automatic test_store;
    run_txn(1'b1, 1'b1, 32'h302, 32'h1234ABCD, 3'b001, 1, 32'h0, 1'b0);
    n_tests++; if (o_we !== 1'b1 || o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_we_be: got %b/%b expected 1/1100", o_we, o_be); end
    n_tests++; if (o_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h expected abcdabcd", o_wdata); end
    n_tests++; if (o_err !== 1'b0 || o_lat !== 3) begin n_fail++; $display("FAIL sh_done: got err=%b lat=%0d expected 0 3", o_err, o_lat); end
    n_tests++; if (o_mdr !== m_mdr) begin n_fail++; $display("FAIL sh_mdr_kept: got %h expected %h", o_mdr, m_mdr); end
    run_txn(1'b1, 1'b1, 32'h301, 32'hCAFE005A, 3'b000, 0, 32'h0, 1'b0);
    n_tests++; if (o_be !== 4'b0010 || o_wdata !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL sb_lanes: got %b/%h expected 0010/5a5a5a5a", o_be, o_wdata); end
  endtask

  task automatic test_misaligned;
    logic [2:0] f3s [3] = '{3'b010, 3'b011, 3'b100};
    logic [31:0] adr [3] = '{32'h401, 32'h400, 32'h400};
    for (int i = 0; i < 3; i++) begin
      run_txn(i == 2, 1'b1, adr[i], 32'hFFFFFFFF, f3s[i], 0, 32'h11111111, 1'b0);
      n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL err%0d_no_req: got %b expected 0", i, o_req); end
      n_tests++; if (o_lat !== 1 || o_err !== 1'b1) begin
        n_fail++; $display("FAIL err%0d_resp: got lat=%0d err=%b expected 1 1", i, o_lat, o_err); end
      n_tests++; if (o_mdr !== m_mdr || o_ir !== m_ir) begin
        n_fail++; $display("FAIL err%0d_regs_kept: got %h/%h expected %h/%h", i, o_ir, o_mdr, m_ir, m_mdr); end
    end
  endtask

  task automatic test_ignore_cmd;
    run_txn(1'b0, 1'b1, 32'h708, 32'h0, 3'b010, 2, 32'h13572468, 1'b1);
    n_tests++; if (o_lat !== 4 || o_mdr !== 32'h13572468) begin
      n_fail++; $display("FAIL ignore_txn: got lat=%0d mdr=%h expected 4 13572468", o_lat, o_mdr); end
    n_tests++; if (o_busy2 !== 1'b0) begin n_fail++; $display("FAIL ignore_no_new_txn: got busy=%b expected 0", o_busy2); end
    m_mdr = 32'h13572468;
  endtask

  task automatic test_clr;
    bit saw_done = 0;
    @(negedge clk);
    MemoryRead = 1; IorD = 1; alu_out = 32'h600; func3 = 3'b010;
    @(posedge clk); #1; MemoryRead = 0;
    @(posedge clk); #1;
    n_tests++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL clr_pre_req: got %b expected 1", bus_req); end
    #2 clr = 1;
    #1;
    n_tests++; if (bus_req !== 1'b0 || ir !== 32'h00000013 || mem_busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_immediate: got req=%b ir=%h busy=%b expected 0 00000013 0", bus_req, ir, mem_busy); end
    @(negedge clk); clr = 0; bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (mem_done) saw_done = 1;
    end
    bus_ack = 0;
    n_tests++; if (saw_done !== 1'b0 || mdr !== 32'h0) begin
      n_fail++; $display("FAIL clr_late_ack: got done=%b mdr=%h expected 0 0", saw_done, mdr); end
    m_ir = 32'h00000013; m_mdr = 32'h0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      bit          wr, iord, bad;
      logic [31:0] a, wd, rd;
      logic [2:0]  f3;
      int          w, sz;
      wr = ($urandom % 3) == 0; iord = ($urandom % 4) != 0;
      a = $urandom; if (!iord && ($urandom % 4) != 0) a = a & ~32'h3;
      if (iord && ($urandom % 2)) a = a & ~32'h1;
      wd = $urandom; rd = $urandom; f3 = 3'($urandom); w = $urandom_range(0, 3);
      sz = m_size(iord, f3);
      bad = m_bad(wr, iord, f3, a);
      if (!bad && !wr) begin
        if (iord) m_mdr = m_load(f3, a, rd);
        else m_ir = rd;
      end
      run_txn(wr, iord, a, wd, f3, w, rd, 1'b0);
      n_tests++; if (o_err !== bad || o_lat !== (bad ? 1 : w + 2)) begin
        n_fail++; $display("FAIL rnd%0d_resp: got err=%b lat=%0d expected %b %0d", i, o_err, o_lat, bad, bad ? 1 : w + 2); end
      n_tests++; if (o_ir !== m_ir || o_mdr !== m_mdr) begin
        n_fail++; $display("FAIL rnd%0d_regs: got %h/%h expected %h/%h", i, o_ir, o_mdr, m_ir, m_mdr); end
      n_tests++; if (o_req !== !bad) begin n_fail++; $display("FAIL rnd%0d_req: got %b expected %b", i, o_req, !bad); end
      if (!bad) begin
        n_tests++; if (o_addr !== (a & ~32'h3) || o_be !== m_be(sz, a) || o_we !== wr || o_stable !== 1'b1) begin
          n_fail++; $display("FAIL rnd%0d_bus: got %h/%b/%b/%b expected %h/%b/%b/1", i, o_addr, o_be, o_we, o_stable, a & ~32'h3, m_be(sz, a), wr); end
        if (wr) begin
          n_tests++; if (o_wdata !== m_wd(sz, wd)) begin
            n_fail++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, o_wdata, m_wd(sz, wd)); end
        end
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    run_txn(1'b0, 1'b1, 32'h500, 32'h0, 3'b010, -1, 32'h0, 1'b0);
    n_tests++; if (o_lat !== 5 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_resp: got lat=%0d err=%b expected 5 1", o_lat, o_err); end
    n_tests++; if (o_mdr !== m_mdr || o_busy2 !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after: got mdr=%h busy=%b expected %h 0", o_mdr, o_busy2, m_mdr); end
    run_txn(1'b0, 1'b1, 32'h504, 32'h0, 3'b010, 3, 32'h24681357, 1'b0);
    n_tests++; if (o_lat !== 5 || o_err !== 1'b0 || o_mdr !== 32'h24681357) begin
      n_fail++; $display("FAIL timeout_ack_wins: got lat=%0d err=%b mdr=%h expected 5 0 24681357", o_lat, o_err, o_mdr); end
    m_mdr = 32'h24681357;
  endtask
`else
  task automatic test_long_wait;
    run_txn(1'b0, 1'b1, 32'h504, 32'h0, 3'b010, 300, 32'h24681357, 1'b0);
    n_tests++; if (o_lat !== 302 || o_err !== 1'b0 || o_mdr !== 32'h24681357) begin
      n_fail++; $display("FAIL long_wait: got lat=%0d err=%b mdr=%h expected 302 0 24681357", o_lat, o_err, o_mdr); end
    m_mdr = 32'h24681357;
  endtask
`endif

  initial begin
    test_reset;
    test_fetch;
    test_loads;
    test_store;
    test_misaligned;
    test_ignore_cmd;
    test_clr;
    test_random;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`else
    test_long_wait;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
